// File: rtl/mult_share_arb.sv
// mult_share_arb
// Shares one sign-magnitude Q0.9 fractional multiplier among NREQ requesters.
// A round-robin arbiter grants one request per cycle into a two-stage
// registered pipeline. Each result is tagged with the issuing requester ID.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-requester request valid
//   req_ready  - per-requester accept (one-hot or zero)
//   req_a      - packed operand A, requester i in bits [10i+9:10i]
//   req_b      - packed operand B, same packing as req_a
//   res_valid  - result valid
//   res_ready  - downstream accept
//   res_c      - product, sign-magnitude Q0.9
//   res_id     - index of the requester that issued the result
//   op_count   - saturating count of completed results
//   busy       - high while either pipeline stage holds an entry
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*10-1:0]   req_a,
    input  logic [NREQ*10-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [9:0]           res_c,
    output logic [IDW-1:0]       res_id,
    output logic [CNTW-1:0]      op_count,
    output logic                 busy
);

    logic [IDW-1:0]  rrPtr_q, rrPtr_d;
    logic            s1Valid_q, s1Valid_d;
    logic [9:0]      s1A_q, s1A_d;
    logic [9:0]      s1B_q, s1B_d;
    logic [IDW-1:0]  s1Id_q, s1Id_d;
    logic            s2Valid_q, s2Valid_d;
    logic [9:0]      resC_q, resC_d;
    logic [IDW-1:0]  resId_q, resId_d;
    logic [CNTW-1:0] opCount_q, opCount_d;

    logic            winFound;
    logic [IDW-1:0]  winIdx;
    logic            s2Adv;
    logic            s1Free;
    logic            accept;
    logic            outXfer;
    logic [17:0]     prod;

    // Pipeline flow control: stage 2 can take stage 1's entry when it is
    // empty or being drained this cycle, and stage 1 can take a new request
    // when it is empty or moving forward, so all three can happen together.
    assign s2Adv   = s1Valid_q & (~s2Valid_q | res_ready);
    assign s1Free  = ~s1Valid_q | s2Adv;
    assign accept  = winFound & s1Free;
    assign outXfer = s2Valid_q & res_ready;

    // Round-robin search starting at the pointer and wrapping around. The
    // index is kept below NREQ, so upper ID bits stay zero automatically.
    always_comb begin
        int idx;
        winFound = 1'b0;
        winIdx   = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!winFound && req_valid[idx]) begin
                winFound = 1'b1;
                winIdx   = IDW'(idx);
            end
        end
    end

    // Only the winner sees ready, and only when stage 1 can take it.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winIdx] = 1'b1;
        end
    end

    // Unsigned 9x9 magnitude product; the result keeps the top nine bits,
    // which truncates toward zero. The sign is a plain XOR, so a zero
    // magnitude may come out as negative zero.
    assign prod = {9'b0, s1A_q[8:0]} * {9'b0, s1B_q[8:0]};

    // Next-state logic for the pointer, both pipeline stages and the counter.
    always_comb begin
        rrPtr_d   = rrPtr_q;
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Id_d    = s1Id_q;
        s2Valid_d = s2Valid_q;
        resC_d    = resC_q;
        resId_d   = resId_q;
        opCount_d = opCount_q;

        if (accept) begin
            rrPtr_d = (winIdx == IDW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
        end

        if (accept) begin
            s1Valid_d = 1'b1;
            s1A_d     = req_a[int'(winIdx) * 10 +: 10];
            s1B_d     = req_b[int'(winIdx) * 10 +: 10];
            s1Id_d    = winIdx;
        end else if (s2Adv) begin
            s1Valid_d = 1'b0;
        end

        if (s2Adv) begin
            s2Valid_d = 1'b1;
            resC_d    = {s1A_q[9] ^ s1B_q[9], prod[17:9]};
            resId_d   = s1Id_q;
        end else if (outXfer) begin
            s2Valid_d = 1'b0;
        end

        if (outXfer && !(&opCount_q)) begin
            opCount_d = opCount_q + 1'b1;
        end
    end

    // State registers; reset throws away anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q   <= '0;
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Id_q    <= '0;
            s2Valid_q <= 1'b0;
            resC_q    <= '0;
            resId_q   <= '0;
            opCount_q <= '0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            s1Valid_q <= s1Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Id_q    <= s1Id_d;
            s2Valid_q <= s2Valid_d;
            resC_q    <= resC_d;
            resId_q   <= resId_d;
            opCount_q <= opCount_d;
        end
    end

    assign res_valid = s2Valid_q;
    assign res_c     = resC_q;
    assign res_id    = resId_q;
    assign op_count  = opCount_q;
    assign busy      = s1Valid_q | s2Valid_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb
// Self-checking bench for mult_share_arb, built with a 4-bit op counter so
// saturation can be reached quickly. Inputs change on the falling edge and
// outputs are sampled just after it.
module tb_mult_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] expC;
    } arithVec_t;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*10-1:0]  req_a;
    logic [NREQ*10-1:0]  req_b;
    logic                res_valid;
    logic                res_ready;
    logic [9:0]          res_c;
    logic [IDW-1:0]      res_id;
    logic [CNTW-1:0]     op_count;
    logic                busy;

    int checkCount = 0;
    int errorCount = 0;

    mult_share_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c     (res_c),
        .res_id    (res_id),
        .op_count  (op_count),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference product from the arithmetic definition.
    function automatic logic [9:0] mulModel(input logic [9:0] a, input logic [9:0] b);
        logic [17:0] p;
        p = {9'b0, a[8:0]} * {9'b0, b[8:0]};
        return {a[9] ^ b[9], p[17:9]};
    endfunction

    // Put one operand in a requester's slot of a packed bus.
    function automatic logic [NREQ*10-1:0] place(input int idx, input logic [9:0] val);
        logic [NREQ*10-1:0] r;
        r = '0;
        r[idx*10 +: 10] = val;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*10-1:0] a,
                                 input logic [NREQ*10-1:0] b, input logic rdy);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        res_ready = rdy;
    endtask

    // Hold reset across a falling edge, check the cleared state, and release
    // it on that falling edge.
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus('0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_op_count",  32'(op_count),  32'd0);
        checkOutput("rst_res_c",     32'(res_c),     32'd0);
        checkOutput("rst_res_id",    32'(res_id),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        arithVec_t  vecs[6];
        logic [9:0] rrA[NREQ];
        logic [9:0] rrB[NREQ];
        logic [NREQ*10-1:0] allA;
        logic [NREQ*10-1:0] allB;
        int         grantOrder[6];
        logic [9:0] bpA[6];
        logic [9:0] bpB[6];
        logic       rdySched[12];
        logic       expReady[9];
        logic [9:0] expQ[$];
        logic [9:0] holdC;
        logic [IDW-1:0] holdId;
        logic       holdValid;
        int         nextOp;
        int         gotCount;
        int         seen;
        logic       rdy;
        logic [9:0] opA;
        logic [9:0] opB;
        logic [9:0] expected;

        vecs[0] = '{a: 10'h100, b: 10'h100, expC: 10'h080};
        vecs[1] = '{a: 10'h300, b: 10'h100, expC: 10'h280};
        vecs[2] = '{a: 10'h1FF, b: 10'h1FF, expC: 10'h1FE};
        vecs[3] = '{a: 10'h200, b: 10'h005, expC: 10'h200};
        vecs[4] = '{a: 10'h0FF, b: 10'h002, expC: 10'h000};
        vecs[5] = '{a: 10'h180, b: 10'h380, expC: 10'h320};

        rst_n = 1'b0;
        applyStimulus('0, '0, '0, 1'b0);
        doReset();

        // Arithmetic through requester 0, two-cycle latency each.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001, place(0, vecs[i].a), place(0, vecs[i].b), 1'b1);
            #1;
            checkOutput("arith_req_ready", 32'(req_ready), 32'h1);
            @(negedge clk);
            applyStimulus('0, '0, '0, 1'b1);
            #1;
            checkOutput("arith_early_valid", 32'(res_valid), 32'd0);
            @(negedge clk);
            #1;
            checkOutput("arith_res_valid", 32'(res_valid), 32'd1);
            checkOutput("arith_res_c",     32'(res_c),     32'(vecs[i].expC));
            checkOutput("arith_res_id",    32'(res_id),    32'd0);
        end
        @(negedge clk);
        #1;
        checkOutput("arith_op_count", 32'(op_count), 32'd6);

        // All requesters active: grants rotate 0,1,2,3,0,1.
        doReset();
        grantOrder = '{0, 1, 2, 3, 0, 1};
        allA = '0;
        allB = '0;
        for (int r = 0; r < NREQ; r++) begin
            rrA[r] = 10'(64 * (r + 1)) | ((r % 2 == 1) ? 10'h200 : 10'h000);
            rrB[r] = 10'h1FF - 10'(r * 32);
            allA[r*10 +: 10] = rrA[r];
            allB[r*10 +: 10] = rrB[r];
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 6) applyStimulus(4'b1111, allA, allB, 1'b1);
            else       applyStimulus('0, '0, '0, 1'b1);
            #1;
            if (i < 6) checkOutput("rr_grant", 32'(req_ready), 32'(1 << grantOrder[i]));
            if (i >= 2) begin
                expected = mulModel(rrA[grantOrder[i-2]], rrB[grantOrder[i-2]]);
                checkOutput("rr_res_valid", 32'(res_valid), 32'd1);
                checkOutput("rr_res_id",    32'(res_id),    32'(grantOrder[i-2]));
                checkOutput("rr_res_c",     32'(res_c),     32'(expected));
            end
            @(negedge clk);
        end
        #1;
        checkOutput("rr_op_count",   32'(op_count),  32'd6);
        checkOutput("rr_drained",    32'(res_valid), 32'd0);

        // Pointer behaviour: move it to 2, then check wrap-dependent priority.
        doReset();
        applyStimulus(4'b0010, allA, allB, 1'b1);
        #1;
        checkOutput("ptr_first_1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        applyStimulus(4'b1010, allA, allB, 1'b1);
        #1;
        checkOutput("ptr_3_before_1", 32'(req_ready), 32'b1000);
        @(negedge clk);
        applyStimulus(4'b0011, allA, allB, 1'b1);
        #1;
        checkOutput("ptr_wrapped_0_first", 32'(req_ready), 32'b0001);
        @(negedge clk);
        applyStimulus(4'b0011, allA, allB, 1'b1);
        #1;
        checkOutput("ptr_1_before_0", 32'(req_ready), 32'b0010);
        @(negedge clk);
        applyStimulus(4'b1001, allA, allB, 1'b1);
        #1;
        checkOutput("ptr_from_2_picks_3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        applyStimulus('0, '0, '0, 1'b1);
        repeat (3) @(negedge clk);

        // Backpressure: requester 2 streams while res_ready drops for 4 cycles.
        doReset();
        for (int i = 0; i < 6; i++) begin
            bpA[i] = 10'h040 + 10'(i * 48) + ((i % 3 == 0) ? 10'h200 : 10'h000);
            bpB[i] = 10'h1F0 - 10'(i * 20);
        end
        rdySched = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        expReady = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        nextOp    = 0;
        gotCount  = 0;
        holdValid = 1'b0;
        holdC     = '0;
        holdId    = '0;
        for (int c = 0; c < 16; c++) begin
            rdy = (c < 12) ? rdySched[c] : 1'b1;
            opA = (nextOp < 6) ? bpA[nextOp] : 10'h000;
            opB = (nextOp < 6) ? bpB[nextOp] : 10'h000;
            applyStimulus((nextOp < 6) ? 4'b0100 : 4'b0000, place(2, opA), place(2, opB), rdy);
            #1;
            if (c < 9) checkOutput("bp_req_ready", 32'(req_ready), expReady[c] ? 32'b0100 : 32'b0000);
            if (holdValid) begin
                checkOutput("bp_stable_c",  32'(res_c),  32'(holdC));
                checkOutput("bp_stable_id", 32'(res_id), 32'(holdId));
            end
            holdValid = res_valid & ~res_ready;
            holdC     = res_c;
            holdId    = res_id;
            if (res_valid && res_ready) begin
                checkOutput("bp_no_extra", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    expected = expQ.pop_front();
                    checkOutput("bp_res_c",  32'(res_c),  32'(expected));
                    checkOutput("bp_res_id", 32'(res_id), 32'd2);
                end
                gotCount++;
            end
            if (req_ready[2]) begin
                expQ.push_back(mulModel(opA, opB));
                nextOp++;
            end
            @(negedge clk);
        end
        #1;
        checkOutput("bp_all_accepted", 32'(nextOp),   32'd6);
        checkOutput("bp_all_returned", 32'(gotCount), 32'd6);
        checkOutput("bp_op_count",     32'(op_count), 32'd6);

        // Reset while both stages are full.
        applyStimulus(4'b0010, place(1, 10'h155), place(1, 10'h0AA), 1'b0);
        @(negedge clk);
        applyStimulus(4'b0010, place(1, 10'h1AA), place(1, 10'h055), 1'b0);
        @(negedge clk);
        #1;
        checkOutput("mid_full_valid", 32'(res_valid), 32'd1);
        checkOutput("mid_full_busy",  32'(busy),      32'd1);
        applyStimulus('0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid",    32'(res_valid), 32'd0);
        checkOutput("mid_rst_busy",     32'(busy),      32'd0);
        checkOutput("mid_rst_op_count", 32'(op_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_post_valid", 32'(res_valid), 32'd0);
        applyStimulus(4'b1000, place(3, 10'h100), place(3, 10'h300), 1'b1);
        #1;
        checkOutput("mid_post_ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        applyStimulus('0, '0, '0, 1'b1);
        #1;
        checkOutput("mid_post_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("mid_post_res_valid", 32'(res_valid), 32'd1);
        checkOutput("mid_post_res_c",     32'(res_c),     32'h280);
        checkOutput("mid_post_res_id",    32'(res_id),    32'd3);
        @(negedge clk);
        #1;
        checkOutput("mid_post_op_count",  32'(op_count),  32'd1);
        checkOutput("mid_post_drained",   32'(res_valid), 32'd0);

        // Counter saturation with a 4-bit counter: 18 transfers end at 15.
        doReset();
        seen = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 18) applyStimulus(4'b0001, place(0, 10'h1FF), place(0, 10'h100), 1'b1);
            else        applyStimulus('0, '0, '0, 1'b1);
            #1;
            checkOutput("sat_op_count", 32'(op_count), 32'((seen > 15) ? 15 : seen));
            if (res_valid && res_ready) seen++;
            @(negedge clk);
        end
        #1;
        checkOutput("sat_transfers", 32'(seen),     32'd18);
        checkOutput("sat_final",     32'(op_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one sign-magnitude fractional multiplier among NREQ requesters.
- Round-robin arbitration, a valid/ready handshake on each request port, and a 2-stage registered pipeline.
- Each result carries the ID of the requester that issued it.
- Sits between the transform/filter engines and the single multiplier resource, so each engine no longer needs its own multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of res_id; must be at least ceil(log2(NREQ)).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*10  operand A per requester; requester i uses bits [10i+9:10i]; bit 9 is the sign, bits 8:0 are the magnitude (Q0.9).
- req_b  in  NREQ*10  operand B, same packing as req_a.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_c  out  10  product, sign-magnitude Q0.9.
- res_id  out  IDW  index of the requester that issued the result.
- op_count  out  CNTW  number of completed results; saturates at its maximum.
- busy  out  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync release): s1_v=0, s2_v=0, rr_ptr=0, res_c=0, res_id=0, op_count=0. Consequently res_valid=0, busy=0, req_ready=0.
- Arithmetic:
  - res_c[9] = a[9] XOR b[9].
  - res_c[8:0] = bits [17:9] of (a[8:0] * b[8:0]), an unsigned 18-bit product truncated toward zero; no rounding, no saturation.
  - Negative zero is permitted and is not normalized (sign = XOR even when the magnitude is 0).
- Arbitration:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first set bit wins and the grant is combinational.
  - req_ready[w] = winner exists AND s1_free; all other req_ready bits are 0.
  - A handshake (req_valid[w] & req_ready[w]) sets rr_ptr to (w+1) mod NREQ.
  - With no handshake, rr_ptr holds.
  - A requester may drop req_valid without a handshake; there is no lock.
- Pipeline:
  - Stage 1 latches the winner's a, b and id on the handshake.
  - Stage 2 holds the computed product plus id and drives res_*; res_valid = s2_v.
  - s2_adv = s1_v & (!s2_v | res_ready).
  - s1_free = !s1_v | s2_adv.
- Latency and throughput:
  - Handshake at edge k gives res_valid high after edge k+1, with a full-throughput pipe and res_ready high.
  - Sustains one operation per clock when res_ready stays high.
- Backpressure:
  - While res_valid & !res_ready, stage 2 holds res_c and res_id stable.
  - Stage 1 fills at most once more, then req_ready drops to 0.
  - No result is ever dropped or duplicated.
- Output handshake:
  - A transfer occurs when res_valid & res_ready.
  - On a transfer, op_count increments by 1, or stays at 2^CNTW-1 if already saturated.
  - Simultaneous drain of stage 2, advance of stage 1 to stage 2, and a new accept into stage 1 in the same cycle is legal and required.
- Mid-operation reset: rst_n low discards all in-flight entries immediately (valids cleared asynchronously). No result is produced for them after release.
- Unused id bits above ceil(log2(NREQ)) are 0.

Test Plan:
- Arithmetic, single requester 0, res_ready=1:
  - a=0x100, b=0x100 -> res_c=0x080.
  - a=0x300, b=0x100 -> res_c=0x280.
  - a=0x1FF, b=0x1FF -> res_c=0x1FE.
  - a=0x200, b=0x005 -> res_c=0x200 (negative zero).
- All 4 requesters holding req_valid, res_ready=1 -> accepts in order 0,1,2,3,0,1; one per cycle; res_id follows the same sequence 2 cycles later; op_count=6 after 6 results.
- Requesters 1 and 3 valid with rr_ptr=2 -> 3 granted first, then 1; requester 0 asserting mid-run is served before 1 only if rr_ptr has wrapped to 0.
- Stream from requester 2, res_ready low for 4 cycles -> res_c/res_id stable, req_ready low after one further accept; after release, every accepted operand pair appears exactly once, in order.
- rst_n pulsed low while both stages are valid -> res_valid=0 immediately, op_count=0; first post-reset request returns its own product with latency 2.
- op_count preloaded by running 2^CNTW-1 transfers (CNTW=4 build: 15) -> further transfers keep op_count=15.
